// File: rtl/multicycle_stage_ctrl_pkg.sv
// State encoding and stage indices for the multi-cycle stage sequencer,
// shared with any display logic that decodes cur_stage.
package multicycle_stage_ctrl_pkg;

    localparam int unsigned STATE_W  = 3;
    localparam int unsigned N_STAGES = 5;

    typedef enum logic [STATE_W-1:0] {
        S_IDLE = 3'd0,
        S_IF   = 3'd1,
        S_ID   = 3'd2,
        S_EXE  = 3'd3,
        S_MEM  = 3'd4,
        S_WB   = 3'd5,
        S_HALT = 3'd6
    } state_t;

    localparam int unsigned STG_IF  = 0;
    localparam int unsigned STG_ID  = 1;
    localparam int unsigned STG_EXE = 2;
    localparam int unsigned STG_MEM = 3;
    localparam int unsigned STG_WB  = 4;

    // True while an instruction occupies one of the five pipeline stages.
    function automatic logic is_stage(input state_t s);
        return (s == S_IF) || (s == S_ID) || (s == S_EXE) || (s == S_MEM) || (s == S_WB);
    endfunction

endpackage

// File: rtl/multicycle_stage_ctrl_stall_wdog.sv
// Per-stage stall watchdog: counts cycles spent in one stage and trips on the
// last allowed cycle if that stage still has not finished. STALL_TIMEOUT=0 disables it.
module multicycle_stage_ctrl_stall_wdog #(
    parameter int unsigned STALL_TIMEOUT = 1024
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic count_en,
    input  logic over,
    output logic trip
);

    localparam int unsigned WD_W  = (STALL_TIMEOUT > 1) ? $clog2(STALL_TIMEOUT) : 1;
    localparam int unsigned LIMIT = (STALL_TIMEOUT == 0) ? 0 : STALL_TIMEOUT - 1;

    logic [WD_W-1:0] cnt;

    assign trip = (STALL_TIMEOUT != 0) && count_en && !over && (cnt == WD_W'(LIMIT));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (clear || trip) begin
            cnt <= '0;
        end else if (count_en) begin
            cnt <= cnt + WD_W'(1);
        end
    end

endmodule

// File: rtl/multicycle_stage_ctrl.sv
// Five-stage multi-cycle CPU sequencer: one instruction in flight, one stage strobe at a time.
// Optional performance counters are built only when MC_PERF_CNT_EN is defined.
module multicycle_stage_ctrl
    import multicycle_stage_ctrl_pkg::*;
#(
    parameter int unsigned STALL_TIMEOUT = 1024,
    parameter int unsigned CNT_W         = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             IF_over,
    input  logic             ID_over,
    input  logic             EXE_over,
    input  logic             MEM_over,
    input  logic             WB_over,
    input  logic             halt_req,
    input  logic             resume,
    output logic             IF_valid,
    output logic             ID_valid,
    output logic             EXE_valid,
    output logic             MEM_valid,
    output logic             WB_valid,
    output logic             IF_ID_en,
    output logic             ID_EXE_en,
    output logic             EXE_MEM_en,
    output logic             MEM_WB_en,
    output logic             next_fetch,
    output logic [2:0]       cur_stage,
    output logic             halted,
    output logic             timeout_err,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] inst_cnt
);

    state_t              state;
    logic [N_STAGES-1:0] stage_vld;
    logic [N_STAGES-1:0] over_vec;
    logic                stage_over;
    logic                in_stage;
    logic                trip;

    // Everything visible is decoded from the state register, so reset clears it at once.
    assign stage_vld[STG_IF]  = (state == S_IF);
    assign stage_vld[STG_ID]  = (state == S_ID);
    assign stage_vld[STG_EXE] = (state == S_EXE);
    assign stage_vld[STG_MEM] = (state == S_MEM);
    assign stage_vld[STG_WB]  = (state == S_WB);

    assign over_vec[STG_IF]  = IF_over;
    assign over_vec[STG_ID]  = ID_over;
    assign over_vec[STG_EXE] = EXE_over;
    assign over_vec[STG_MEM] = MEM_over;
    assign over_vec[STG_WB]  = WB_over;

    assign stage_over = |(stage_vld & over_vec);
    assign in_stage   = is_stage(state);

    assign IF_valid   = stage_vld[STG_IF];
    assign ID_valid   = stage_vld[STG_ID];
    assign EXE_valid  = stage_vld[STG_EXE];
    assign MEM_valid  = stage_vld[STG_MEM];
    assign WB_valid   = stage_vld[STG_WB];

    assign IF_ID_en   = IF_valid  & IF_over;
    assign ID_EXE_en  = ID_valid  & ID_over;
    assign EXE_MEM_en = EXE_valid & EXE_over;
    assign MEM_WB_en  = MEM_valid & MEM_over;
    assign next_fetch = WB_valid  & WB_over;

    assign cur_stage  = state;
    assign halted     = (state == S_HALT);

    // Counter restarts whenever the active stage completes or no stage is active.
    multicycle_stage_ctrl_stall_wdog #(
        .STALL_TIMEOUT(STALL_TIMEOUT)
    ) u_wdog (
        .clk      (clk),
        .reset    (reset),
        .clear    (!in_stage || stage_over),
        .count_en (in_stage),
        .over     (stage_over),
        .trip     (trip)
    );

    // A watchdog trip wins over a stalled stage; an on-time *_over never trips.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            timeout_err <= 1'b0;
        end else begin
            timeout_err <= timeout_err | trip;
            case (state)
                S_IDLE: state <= S_IF;
                S_IF:   if (trip) state <= S_HALT; else if (IF_over)  state <= S_ID;
                S_ID:   if (trip) state <= S_HALT; else if (ID_over)  state <= S_EXE;
                S_EXE:  if (trip) state <= S_HALT; else if (EXE_over) state <= S_MEM;
                S_MEM:  if (trip) state <= S_HALT; else if (MEM_over) state <= S_WB;
                S_WB: begin
                    if (trip)         state <= S_HALT;
                    else if (WB_over) state <= halt_req ? S_HALT : S_IF;
                end
                S_HALT: if (resume && !timeout_err) state <= S_IF;
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef MC_PERF_CNT_EN
    logic [CNT_W-1:0] cycle_q;
    logic [CNT_W-1:0] inst_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cycle_q <= '0;
            inst_q  <= '0;
        end else begin
            if (in_stage)   cycle_q <= cycle_q + CNT_W'(1);
            if (next_fetch) inst_q  <= inst_q + CNT_W'(1);
        end
    end

    assign cycle_cnt = cycle_q;
    assign inst_cnt  = inst_q;
`else
    assign cycle_cnt = '0;
    assign inst_cnt  = '0;
`endif

endmodule

// File: tb/tb_multicycle_stage_ctrl.sv
// Scoreboard bench for multicycle_stage_ctrl: directed per-cycle vectors with
// hand-computed expectations, checked by an independent monitor process.
`timescale 1ns/1ps
module tb_multicycle_stage_ctrl;

    localparam int unsigned CNT_W = 32;
    localparam logic [2:0] T_IDLE = 3'd0, T_IF = 3'd1, T_ID = 3'd2, T_EXE = 3'd3,
                           T_MEM = 3'd4, T_WB = 3'd5, T_HALT = 3'd6;
`ifdef MC_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic clk, reset;
    logic IF_over, ID_over, EXE_over, MEM_over, WB_over, halt_req, resume;
    logic IF_valid, ID_valid, EXE_valid, MEM_valid, WB_valid;
    logic IF_ID_en, ID_EXE_en, EXE_MEM_en, MEM_WB_en, next_fetch;
    logic [2:0] cur_stage;
    logic halted, timeout_err;
    logic [CNT_W-1:0] cycle_cnt, inst_cnt;

    typedef struct packed {
        logic [2:0]       st;
        logic [3:0]       en;
        logic             nf;
        logic             to;
        logic             cc;
        logic [CNT_W-1:0] cyc;
        logic [CNT_W-1:0] inst;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   mon_idx = 0;
    logic probe   = 1'b0;
    logic want_cc;
    logic [CNT_W-1:0] want_cyc, want_inst;
    exp_t me;
    logic [14:0] act_v, exp_v;

    multicycle_stage_ctrl #(
        .STALL_TIMEOUT(8),
        .CNT_W        (CNT_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .IF_over    (IF_over),
        .ID_over    (ID_over),
        .EXE_over   (EXE_over),
        .MEM_over   (MEM_over),
        .WB_over    (WB_over),
        .halt_req   (halt_req),
        .resume     (resume),
        .IF_valid   (IF_valid),
        .ID_valid   (ID_valid),
        .EXE_valid  (EXE_valid),
        .MEM_valid  (MEM_valid),
        .WB_valid   (WB_valid),
        .IF_ID_en   (IF_ID_en),
        .ID_EXE_en  (ID_EXE_en),
        .EXE_MEM_en (EXE_MEM_en),
        .MEM_WB_en  (MEM_WB_en),
        .next_fetch (next_fetch),
        .cur_stage  (cur_stage),
        .halted     (halted),
        .timeout_err(timeout_err),
        .cycle_cnt  (cycle_cnt),
        .inst_cnt   (inst_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [4:0] dec_valid(input logic [2:0] s);
        case (s)
            T_IF:    return 5'b10000;
            T_ID:    return 5'b01000;
            T_EXE:   return 5'b00100;
            T_MEM:   return 5'b00010;
            T_WB:    return 5'b00001;
            default: return 5'b00000;
        endcase
    endfunction

    // Monitor: one expectation per cycle at the falling edge, or on an async probe.
    always begin
        @(negedge clk or posedge probe);
        if (exp_q.size() != 0) begin
            me = exp_q.pop_front();
            mon_idx++;
            act_v = {cur_stage, IF_valid, ID_valid, EXE_valid, MEM_valid, WB_valid,
                     IF_ID_en, ID_EXE_en, EXE_MEM_en, MEM_WB_en, next_fetch, halted, timeout_err};
            exp_v = {me.st, dec_valid(me.st), me.en, me.nf, (me.st == T_HALT), me.to};
            n_tests++;
            if (act_v !== exp_v) begin
                n_fail++;
                $display("FAIL vec%0d outputs {stage,valids,en,nf,halted,to}: got %b required %b",
                         mon_idx, act_v, exp_v);
            end
            if (me.cc) begin
                n_tests++;
                if (cycle_cnt !== me.cyc || inst_cnt !== me.inst) begin
                    n_fail++;
                    $display("FAIL vec%0d counters: got cycle=%0d inst=%0d required cycle=%0d inst=%0d",
                             mon_idx, cycle_cnt, inst_cnt, me.cyc, me.inst);
                end
            end
        end
    end

    task automatic step(input logic [4:0] ov, input logic hr, input logic rs,
                        input logic [2:0] st, input logic [3:0] en, input logic nf, input logic to);
        exp_t e;
        {IF_over, ID_over, EXE_over, MEM_over, WB_over} = ov;
        halt_req = hr;
        resume   = rs;
        e.st = st; e.en = en; e.nf = nf; e.to = to;
        e.cc = want_cc; e.cyc = want_cyc; e.inst = want_inst;
        want_cc = 1'b0;
        exp_q.push_back(e);
        @(posedge clk); #1;
    endtask

    // Raise reset mid-cycle and check that every output falls without waiting for a clock.
    task automatic async_reset_check(input logic [4:0] ov);
        exp_t e;
        {IF_over, ID_over, EXE_over, MEM_over, WB_over} = ov;
        #1 reset = 1'b1;
        #1;
        e.st = T_IDLE; e.en = 4'b0000; e.nf = 1'b0; e.to = 1'b0;
        e.cc = 1'b1; e.cyc = '0; e.inst = '0;
        exp_q.push_back(e);
        probe = 1'b1;
        #1 probe = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        reset = 1'b1;
        {IF_over, ID_over, EXE_over, MEM_over, WB_over} = 5'b00000;
        halt_req = 1'b0; resume = 1'b0;
        want_cc = 1'b0; want_cyc = '0; want_inst = '0;
        @(posedge clk); #1;

        // Reset state, then *_over activity while still in reset.
        want_cc = 1'b1;
        step(5'b00000, 0, 0, T_IDLE, 4'b0000, 0, 0);
        step(5'b11111, 0, 0, T_IDLE, 4'b0000, 0, 0);
        reset = 1'b0;
        step(5'b11111, 0, 0, T_IDLE, 4'b0000, 0, 0);

        // Scenario 1: every stage done in its first cycle.
        for (int i = 0; i < 4; i++) begin
            step(5'b11111, 0, 0, T_IF,  4'b1000, 0, 0);
            step(5'b11111, 0, 0, T_ID,  4'b0100, 0, 0);
            step(5'b11111, 0, 0, T_EXE, 4'b0010, 0, 0);
            step(5'b11111, 0, 0, T_MEM, 4'b0001, 0, 0);
            step(5'b11111, 0, 0, T_WB,  4'b0000, 1, 0);
        end

        // Scenario 2: MEM stalls 7 cycles, completes on the last watchdog cycle.
        want_cc = 1'b1; want_cyc = PERF ? 32'd20 : 32'd0; want_inst = PERF ? 32'd4 : 32'd0;
        step(5'b11101, 0, 0, T_IF,  4'b1000, 0, 0);
        step(5'b11101, 0, 0, T_ID,  4'b0100, 0, 0);
        step(5'b11101, 0, 0, T_EXE, 4'b0010, 0, 0);
        for (int i = 0; i < 7; i++) step(5'b11101, 0, 0, T_MEM, 4'b0000, 0, 0);
        step(5'b11111, 0, 0, T_MEM, 4'b0001, 0, 0);
        step(5'b11111, 0, 0, T_WB,  4'b0000, 1, 0);

        // Scenario 3: halt on retire, stray resume outside halt, resume after 3 halted cycles.
        step(5'b11111, 0, 0, T_IF,  4'b1000, 0, 0);
        step(5'b11111, 0, 1, T_ID,  4'b0100, 0, 0);
        step(5'b11111, 0, 0, T_EXE, 4'b0010, 0, 0);
        step(5'b11111, 0, 0, T_MEM, 4'b0001, 0, 0);
        step(5'b11111, 1, 0, T_WB,  4'b0000, 1, 0);
        for (int i = 0; i < 3; i++) step(5'b11111, 1, 0, T_HALT, 4'b0000, 0, 0);
        step(5'b00000, 0, 1, T_HALT, 4'b0000, 0, 0);

        // Scenario 4: ID never finishes; watchdog trips after 8 ID cycles, resume is ignored.
        step(5'b11111, 0, 0, T_IF, 4'b1000, 0, 0);
        for (int i = 0; i < 8; i++) step(5'b10111, 0, 0, T_ID, 4'b0000, 0, 0);
        for (int i = 0; i < 3; i++) step(5'b11111, 0, 1, T_HALT, 4'b0000, 0, 1);
        async_reset_check(5'b11111);
        reset = 1'b0;
        step(5'b11111, 0, 0, T_IDLE, 4'b0000, 0, 0);

        // Scenario 5: reset while EXE is stalled and EXE_over is asserted.
        step(5'b11111, 0, 0, T_IF,  4'b1000, 0, 0);
        step(5'b11111, 0, 0, T_ID,  4'b0100, 0, 0);
        step(5'b11011, 0, 0, T_EXE, 4'b0000, 0, 0);
        step(5'b11011, 0, 0, T_EXE, 4'b0000, 0, 0);
        async_reset_check(5'b11111);
        reset = 1'b0;
        step(5'b11111, 0, 0, T_IDLE, 4'b0000, 0, 0);
        step(5'b11111, 0, 0, T_IF,   4'b1000, 0, 0);
        step(5'b11111, 0, 0, T_ID,   4'b0100, 0, 0);

        repeat (2) @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
